if_stage_mt: RTL and testbench
==============================

Name: if_stage_mt

Overview:
Parametrised multi-thread instruction fetch stage for the out-of-order superscalar core. It replaces the fixed two-thread fetch with NUM_THREADS hardware threads, each holding its own PC. Each cycle it selects one eligible thread round-robin and fetches one LINE_W-bit line containing FETCH_W instructions. It handles per-thread redirect, per-thread stalls, global back-pressure and flushing of the registered fetch packet.

Parameters:
NUM_THREADS, 2, number of hardware threads (1..8)
XLEN, 64, PC/address width
INST_W, 32, instruction width
LINE_W, 64, Imem line width; FETCH_W = LINE_W/INST_W slots per fetch
RESET_PC, 0, PC of every thread after reset

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
thread_active  in  NUM_THREADS  thread enabled mask
branch_taken  in  NUM_THREADS  per-thread redirect request
target_pc  in  NUM_THREADS*XLEN  per-thread redirect target
thread_stall  in  NUM_THREADS  per-thread back-pressure (ROB full)
global_stall  in  1  RS/RAT full; freezes fetch and output register
mem_hazard_stall  in  NUM_THREADS  per-thread structural hazard on memory
Imem2proc_data  in  LINE_W  line returned for proc2Imem_addr, same cycle
Imem2proc_valid  in  1  Imem2proc_data valid
proc2Imem_addr  out  XLEN  line-aligned fetch address (combinational)
next_PC_out  out  NUM_THREADS*XLEN  current PC of each thread
inst_out  out  FETCH_W*INST_W  registered fetch packet; slot i = bits [i*INST_W +: INST_W]
inst_valid  out  FETCH_W  per-slot valid
out_tid  out  TID_W  thread of registered packet
out_pc  out  XLEN  PC of slot 0 of registered packet

Behaviour:
- Reset (synchronous, next posedge): all PCs = RESET_PC; inst_out = 0; inst_valid = 0; out_tid = 0; out_pc = 0; rr_ptr = NUM_THREADS-1, so thread 0 wins first. Applies mid-operation regardless of other inputs.
- eligible[t] = thread_active[t] & ~thread_stall[t] & ~mem_hazard_stall[t] & ~branch_taken[t].
- Grant: first eligible thread searching rr_ptr+1, rr_ptr+2, ... with modulo wrap. No grant when none is eligible or global_stall = 1.
- proc2Imem_addr = PC[grant] with low log2(LINE_W/8) bits cleared. With no grant, it shows PC[rr_ptr+1 mod N], aligned.
- fire = grant & Imem2proc_valid & ~global_stall.
- On fire, registered at the next edge:
  - inst_out = Imem2proc_data; out_tid = grant; out_pc = PC[grant].
  - inst_valid slot i = 1 only for slots at or after PC[grant]'s slot offset (0x104 with FETCH_W = 2 gives 2'b10).
  - PC[grant] = aligned PC + LINE_W/8.
  - rr_ptr = grant.
- No fire and ~global_stall: inst_valid = 0; PCs (except redirects) and rr_ptr hold.
- global_stall = 1: inst_out, inst_valid, out_tid and out_pc hold. Flush and redirect still apply.
- Redirect: branch_taken[t] sets PC[t] = target_pc[t] at the next edge. This has priority over stall and over fire, and thread t is never granted in that cycle.
- Flush: branch_taken[out_tid] = 1 clears inst_valid at the next edge, even under global_stall.
- Simultaneous redirects of several threads are all applied. An inactive thread's PC holds but still accepts redirects.
- Imem2proc_valid = 0: nothing advances; the same thread is retried next cycle if it remains eligible.
- PC arithmetic is modulo 2^XLEN; wrap at the top of the address space is silent.

Decomposition:
- Package if_mt_pkg holds:
  - TID_W = max(1, $clog2(NUM_THREADS)) and FETCH_W.
  - typedef fetch_packet_t {inst, valid, tid, pc}.
  - function line_align().
- Sub-module rr_arbiter (NUM_THREADS): inputs req and ptr; outputs one-hot grant, grant index and any_grant. Purely combinational; rr_ptr lives in if_stage_mt.

Test Plan:
- Reset, thread_active = 2'b01, Imem2proc_valid = 1, data 64'h0100_5601_1253_9787 -> proc2Imem_addr = 0. Next cycle: inst_out slot0 = 32'h1253_9787, slot1 = 32'h0100_5601, inst_valid = 2'b11, out_tid = 0, next_PC_out[0] = 8.
- Imem2proc_valid = 0 for 1 cycle, then 1 -> inst_valid = 0 in that cycle, PC0 stays 8, then fetches address 8.
- global_stall = 1 for 2 cycles -> outputs and PCs frozen. Release -> fetch resumes at the held PC.
- branch_taken[0] = 1 with target 64'h104 -> inst_valid cleared next edge. Following fetch: addr 64'h100, inst_valid = 2'b10, then PC0 = 64'h108.
- thread_active = 2'b11, both threads at 0 after reset, no stalls -> out_tid sequence 0,1,0,1 with addresses 0,0,8,8.
- thread_stall[0] = 1 for 3 cycles with two threads -> thread 1 granted every cycle (addresses 0,8,16). Release -> thread 0 granted next. Then reset asserted mid-run -> all PCs = 0, inst_valid = 0 next edge.

Source files
------------

// File: rtl/if_mt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_mt_pkg
//  Description : Shared widths, packet type and line alignment helper for the
//                multi-thread fetch stage.
//  Revision    : 1.0
// ============================================================================
package if_mt_pkg;

    localparam int MAX_XLEN        = 128;
    localparam int DEF_NUM_THREADS = 2;
    localparam int DEF_INST_W      = 32;
    localparam int DEF_LINE_W      = 64;

    function automatic int tid_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int fetch_width(input int line_w, input int inst_w);
        return line_w / inst_w;
    endfunction

    localparam int TID_W   = tid_width(DEF_NUM_THREADS);
    localparam int FETCH_W = fetch_width(DEF_LINE_W, DEF_INST_W);

    typedef struct packed {
        logic [FETCH_W*DEF_INST_W-1:0] inst;
        logic [FETCH_W-1:0]            valid;
        logic [TID_W-1:0]              tid;
        logic [63:0]                   pc;
    } fetch_packet_t;

    // Clears the byte-offset-within-line bits of an address.
    function automatic logic [MAX_XLEN-1:0] line_align(input logic [MAX_XLEN-1:0] addr,
                                                       input int off_bits);
        logic [MAX_XLEN-1:0] mask;
        mask = '1;
        mask = mask << off_bits;
        return addr & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_mt_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter; search starts one past ptr.
//  Revision    : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_THREADS = 2,
    parameter int TID_W       = 1
)(
    input  logic [NUM_THREADS-1:0] req,
    input  logic [TID_W-1:0]       ptr,
    output logic [NUM_THREADS-1:0] grant,
    output logic [TID_W-1:0]       grant_idx,
    output logic                   any_grant
);

    logic [2*NUM_THREADS-1:0] w_dbl;
    logic [NUM_THREADS-1:0]   w_rot;
    int                       w_idx;

    assign w_dbl = {req, req};

    always_comb begin
        w_rot     = NUM_THREADS'(w_dbl >> ((int'(ptr) + 1) % NUM_THREADS));
        w_idx     = 0;
        any_grant = 1'b0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (!any_grant && w_rot[i]) begin
                any_grant = 1'b1;
                w_idx     = (int'(ptr) + 1 + i) % NUM_THREADS;
            end
        end
        grant_idx = TID_W'(w_idx);
        grant     = any_grant ? (NUM_THREADS'(1) << w_idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/if_stage_mt.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_mt
//  Description : Round-robin multi-thread instruction fetch stage with
//                per-thread redirect/stall, global stall and packet flush.
//  Revision    : 1.0
// ============================================================================
module if_stage_mt
    import if_mt_pkg::*;
#(
    parameter int               NUM_THREADS = 2,
    parameter int               XLEN        = 64,
    parameter int               INST_W      = 32,
    parameter int               LINE_W      = 64,
    parameter logic [XLEN-1:0]  RESET_PC    = '0
)(
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [NUM_THREADS-1:0]                        thread_active,
    input  logic [NUM_THREADS-1:0]                        branch_taken,
    input  logic [NUM_THREADS*XLEN-1:0]                   target_pc,
    input  logic [NUM_THREADS-1:0]                        thread_stall,
    input  logic                                          global_stall,
    input  logic [NUM_THREADS-1:0]                        mem_hazard_stall,
    input  logic [LINE_W-1:0]                             Imem2proc_data,
    input  logic                                          Imem2proc_valid,
    output logic [XLEN-1:0]                               proc2Imem_addr,
    output logic [NUM_THREADS*XLEN-1:0]                   next_PC_out,
    output logic [fetch_width(LINE_W, INST_W)*INST_W-1:0] inst_out,
    output logic [fetch_width(LINE_W, INST_W)-1:0]        inst_valid,
    output logic [tid_width(NUM_THREADS)-1:0]             out_tid,
    output logic [XLEN-1:0]                               out_pc
);

    localparam int              c_FETCH_W    = fetch_width(LINE_W, INST_W);
    localparam int              c_TID_W      = tid_width(NUM_THREADS);
    localparam int              c_LINE_BYTES = LINE_W / 8;
    localparam int              c_OFF_BITS   = $clog2(c_LINE_BYTES);
    localparam int              c_INST_BYTES = INST_W / 8;
    localparam logic [XLEN-1:0] c_LINE_INC   = XLEN'(c_LINE_BYTES);

    logic [XLEN-1:0]             r_pc [NUM_THREADS];
    logic [c_TID_W-1:0]          r_rr_ptr;
    logic [c_FETCH_W*INST_W-1:0] r_inst;
    logic [c_FETCH_W-1:0]        r_valid;
    logic [c_TID_W-1:0]          r_tid;
    logic [XLEN-1:0]             r_out_pc;

    logic [NUM_THREADS-1:0]      w_eligible;
    logic [NUM_THREADS-1:0]      w_req;
    logic [NUM_THREADS-1:0]      w_grant_oh;
    logic [c_TID_W-1:0]          w_grant_idx;
    logic                        w_any_grant;
    logic [c_TID_W-1:0]          w_next_ptr;
    logic [c_TID_W-1:0]          w_sel_idx;
    logic [XLEN-1:0]             w_sel_pc;
    logic [XLEN-1:0]             w_sel_aligned;
    logic [c_OFF_BITS-1:0]       w_byte_off;
    logic [c_FETCH_W-1:0]        w_slot_valid;
    logic                        w_fire;

    // A redirected thread is excluded so its stale PC is never fetched.
    assign w_eligible = thread_active & ~thread_stall & ~mem_hazard_stall & ~branch_taken;
    assign w_req      = global_stall ? '0 : w_eligible;

    rr_arbiter #(
        .NUM_THREADS (NUM_THREADS),
        .TID_W       (c_TID_W)
    ) u_arb (
        .req       (w_req),
        .ptr       (r_rr_ptr),
        .grant     (w_grant_oh),
        .grant_idx (w_grant_idx),
        .any_grant (w_any_grant)
    );

    assign w_next_ptr    = (int'(r_rr_ptr) == NUM_THREADS - 1) ? '0 : r_rr_ptr + 1'b1;
    assign w_sel_idx     = w_any_grant ? w_grant_idx : w_next_ptr;
    assign w_sel_pc      = r_pc[w_sel_idx];
    assign w_sel_aligned = XLEN'(line_align(MAX_XLEN'(w_sel_pc), c_OFF_BITS));
    assign w_byte_off    = w_sel_pc[c_OFF_BITS-1:0];
    assign w_fire        = w_any_grant & Imem2proc_valid;

    // Slots before the PC's position in the line belong to earlier code.
    always_comb begin
        w_slot_valid = '0;
        for (int i = 0; i < c_FETCH_W; i++) begin
            w_slot_valid[i] = (i >= (int'(w_byte_off) / c_INST_BYTES));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_pc[t] <= RESET_PC;
            end
            r_rr_ptr <= c_TID_W'(NUM_THREADS - 1);
            r_inst   <= '0;
            r_valid  <= '0;
            r_tid    <= '0;
            r_out_pc <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (branch_taken[t]) begin
                    r_pc[t] <= target_pc[t*XLEN +: XLEN];
                end else if (w_fire && w_grant_oh[t]) begin
                    r_pc[t] <= w_sel_aligned + c_LINE_INC;
                end
            end
            if (w_fire) begin
                r_rr_ptr <= w_grant_idx;
            end
            if (!global_stall) begin
                if (w_fire) begin
                    r_inst   <= Imem2proc_data;
                    r_tid    <= w_grant_idx;
                    r_out_pc <= w_sel_pc;
                    r_valid  <= w_slot_valid;
                end else begin
                    r_valid  <= '0;
                end
            end
            // Flush wins over both hold and a fresh packet.
            if (branch_taken[r_tid]) begin
                r_valid <= '0;
            end
        end
    end

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_pc_out
        assign next_PC_out[t*XLEN +: XLEN] = r_pc[t];
    end

    assign proc2Imem_addr = w_sel_aligned;
    assign inst_out       = r_inst;
    assign inst_valid     = r_valid;
    assign out_tid        = r_tid;
    assign out_pc         = r_out_pc;

endmodule
`default_nettype wire

// File: tb/tb_if_stage_mt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage_mt
//  Description : Directed self-checking bench for if_stage_mt (2 threads).
//  Revision    : 1.0
// ============================================================================
module tb_if_stage_mt;

    logic         clock;
    logic         reset;
    logic [1:0]   thread_active;
    logic [1:0]   branch_taken;
    logic [127:0] target_pc;
    logic [1:0]   thread_stall;
    logic         global_stall;
    logic [1:0]   mem_hazard_stall;
    logic [63:0]  Imem2proc_data;
    logic         Imem2proc_valid;
    logic [63:0]  proc2Imem_addr;
    logic [127:0] next_PC_out;
    logic [63:0]  inst_out;
    logic [1:0]   inst_valid;
    logic [0:0]   out_tid;
    logic [63:0]  out_pc;

    int n_checks = 0;
    int n_fail   = 0;

    if_stage_mt u_dut (
        .clock            (clock),
        .reset            (reset),
        .thread_active    (thread_active),
        .branch_taken     (branch_taken),
        .target_pc        (target_pc),
        .thread_stall     (thread_stall),
        .global_stall     (global_stall),
        .mem_hazard_stall (mem_hazard_stall),
        .Imem2proc_data   (Imem2proc_data),
        .Imem2proc_valid  (Imem2proc_valid),
        .proc2Imem_addr   (proc2Imem_addr),
        .next_PC_out      (next_PC_out),
        .inst_out         (inst_out),
        .inst_valid       (inst_valid),
        .out_tid          (out_tid),
        .out_pc           (out_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset            = 1'b1;
        thread_active    = 2'b00;
        branch_taken     = 2'b00;
        target_pc        = '0;
        thread_stall     = 2'b00;
        global_stall     = 1'b0;
        mem_hazard_stall = 2'b00;
        Imem2proc_data   = '0;
        Imem2proc_valid  = 1'b0;
        step();
        step();
        chk("rst_valid", inst_valid, 2'b00);
        chk("rst_tid",   out_tid, 1'b0);
        chk("rst_pc",    out_pc, 64'h0);
        chk("rst_inst",  inst_out, 64'h0);
        chk("rst_pcs",   next_PC_out, 128'h0);

        // Single thread, first fetch at 0
        reset           = 1'b0;
        thread_active   = 2'b01;
        Imem2proc_valid = 1'b1;
        Imem2proc_data  = 64'h0100_5601_1253_9787;
        #1;
        chk("f1_addr", proc2Imem_addr, 64'h0);
        step();
        chk("f1_slot0", inst_out[31:0], 32'h1253_9787);
        chk("f1_slot1", inst_out[63:32], 32'h0100_5601);
        chk("f1_valid", inst_valid, 2'b11);
        chk("f1_tid",   out_tid, 1'b0);
        chk("f1_pc0",   next_PC_out[63:0], 64'h8);

        // Memory not ready for one cycle
        Imem2proc_valid = 1'b0;
        #1;
        chk("nv_addr", proc2Imem_addr, 64'h8);
        step();
        chk("nv_valid", inst_valid, 2'b00);
        chk("nv_pc0",   next_PC_out[63:0], 64'h8);
        Imem2proc_valid = 1'b1;
        Imem2proc_data  = 64'hAAAA_BBBB_CCCC_DDDD;
        #1;
        chk("f2_addr", proc2Imem_addr, 64'h8);
        step();
        chk("f2_inst",  inst_out, 64'hAAAA_BBBB_CCCC_DDDD);
        chk("f2_valid", inst_valid, 2'b11);
        chk("f2_opc",   out_pc, 64'h8);
        chk("f2_pc0",   next_PC_out[63:0], 64'h10);

        // Global stall for two cycles; no grant shows PC[rr_ptr+1] = PC1
        global_stall   = 1'b1;
        Imem2proc_data = 64'h3333_3333_4444_4444;
        #1;
        chk("gs_addr", proc2Imem_addr, 64'h0);
        step();
        chk("gs1_inst",  inst_out, 64'hAAAA_BBBB_CCCC_DDDD);
        chk("gs1_valid", inst_valid, 2'b11);
        chk("gs1_pc0",   next_PC_out[63:0], 64'h10);
        step();
        chk("gs2_opc",   out_pc, 64'h8);
        chk("gs2_pc0",   next_PC_out[63:0], 64'h10);
        global_stall = 1'b0;
        #1;
        chk("gsr_addr", proc2Imem_addr, 64'h10);
        step();
        chk("gsr_inst", inst_out, 64'h3333_3333_4444_4444);
        chk("gsr_opc",  out_pc, 64'h10);
        chk("gsr_pc0",  next_PC_out[63:0], 64'h18);

        // Redirect thread 0 to 0x104 flushes its packet
        branch_taken = 2'b01;
        target_pc    = {64'h0, 64'h104};
        step();
        chk("br_valid", inst_valid, 2'b00);
        chk("br_pc0",   next_PC_out[63:0], 64'h104);
        branch_taken   = 2'b00;
        Imem2proc_data = 64'h5555_6666_7777_8888;
        #1;
        chk("br_addr", proc2Imem_addr, 64'h100);
        step();
        chk("bf_valid", inst_valid, 2'b10);
        chk("bf_opc",   out_pc, 64'h104);
        chk("bf_pc0",   next_PC_out[63:0], 64'h108);

        // Two threads alternate from reset
        reset = 1'b1;
        step();
        reset         = 1'b0;
        thread_active = 2'b11;
        #1;
        chk("rr1_addr", proc2Imem_addr, 64'h0);
        step();
        chk("rr1_tid", out_tid, 1'b0);
        chk("rr2_addr", proc2Imem_addr, 64'h0);
        step();
        chk("rr2_tid", out_tid, 1'b1);
        chk("rr3_addr", proc2Imem_addr, 64'h8);
        step();
        chk("rr3_tid", out_tid, 1'b0);
        chk("rr4_addr", proc2Imem_addr, 64'h8);
        step();
        chk("rr4_tid", out_tid, 1'b1);
        chk("rr_pcs",  next_PC_out, {64'h10, 64'h10});

        // Thread 0 stalled three cycles: thread 1 takes every slot
        reset = 1'b1;
        step();
        reset        = 1'b0;
        thread_stall = 2'b01;
        #1;
        chk("ts1_addr", proc2Imem_addr, 64'h0);
        step();
        chk("ts1_tid", out_tid, 1'b1);
        chk("ts2_addr", proc2Imem_addr, 64'h8);
        step();
        chk("ts2_tid", out_tid, 1'b1);
        chk("ts3_addr", proc2Imem_addr, 64'h10);
        step();
        chk("ts3_tid", out_tid, 1'b1);
        chk("ts_pcs",  next_PC_out, {64'h18, 64'h0});
        thread_stall = 2'b00;
        #1;
        chk("tsr_addr", proc2Imem_addr, 64'h0);
        step();
        chk("tsr_tid", out_tid, 1'b0);
        chk("tsr_valid", inst_valid, 2'b11);

        // Mid-run reset
        reset = 1'b1;
        step();
        chk("mr_pcs",   next_PC_out, 128'h0);
        chk("mr_valid", inst_valid, 2'b00);
        chk("mr_tid",   out_tid, 1'b0);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
